// File: rtl/mem_if_pkg.sv
// Shared definitions for the DRAM memory-request initiator: operation codes,
// endpoint IDs, issue FSM states and the cache-line offset helper.
package mem_if_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_RD  = 3'b001,
        OP_WR  = 3'b010,
        OP_WB  = 3'b011
    } mem_op_e;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_HOLD = 1'b1
    } issue_state_e;

    localparam logic [1:0] SRC_ID_DEF = 2'd1;
    localparam logic [1:0] MEM_ID_DEF = 2'd3;

    // Number of byte-offset bits inside one cache line
    function automatic int line_off(input int cl_size);
        return $clog2(cl_size / 8);
    endfunction

endpackage

// File: rtl/mem_mshr_table.sv
// Outstanding-read table: one entry per in-flight read, holding the line
// address and whether it was an instruction fetch. Every lookup works on
// registered state only, so a retire and an allocate in the same cycle never
// interfere (the allocated entry is always a currently free one).
module mem_mshr_table
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LW    = 28,
    parameter int IW    = 2,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_en,
    input  logic [LW-1:0] alloc_line,
    input  logic          alloc_instr,
    input  logic          retire_en,
    input  logic [IW-1:0] retire_idx,
    input  logic [LW-1:0] iss_line,
    output logic          iss_hit,
    input  logic [LW-1:0] rsp_line,
    output logic          rsp_hit,
    output logic [IW-1:0] rsp_idx,
    output logic          free,
    output logic [IW-1:0] free_idx,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_instr,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] valid_r;
    logic [LW-1:0]    line_r [DEPTH];
    logic [DEPTH-1:0] instr_r;
    logic [CW-1:0]    count_r;
    logic [DEPTH-1:0] valid_nx_s;
    logic [CW-1:0]    count_nx_s;

    // Lowest-free priority encoder plus the two line CAMs (issue and response)
    always_comb begin
        free     = 1'b0;
        free_idx = {IW{1'b0}};
        iss_hit  = 1'b0;
        rsp_hit  = 1'b0;
        rsp_idx  = {IW{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free     = free | !valid_r[i];
            free_idx = (!valid_r[i]) ? IW'(i) : free_idx;
            iss_hit  = iss_hit | (valid_r[i] && (line_r[i] == iss_line));
            rsp_idx  = (valid_r[i] && (line_r[i] == rsp_line)) ? IW'(i) : rsp_idx;
            rsp_hit  = rsp_hit | (valid_r[i] && (line_r[i] == rsp_line));
        end
    end

    // Next valid vector and its popcount, so the count register tracks valid bits exactly
    always_comb begin
        valid_nx_s = valid_r;
        count_nx_s = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            valid_nx_s[i] = (valid_r[i] && !(retire_en && (retire_idx == IW'(i))))
                          || (alloc_en && (free_idx == IW'(i)));
            count_nx_s    = count_nx_s + CW'(valid_nx_s[i]);
        end
    end

    // Entry storage: allocate into the lowest free slot, retire by index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
            instr_r <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                line_r[i] <= {LW{1'b0}};
            end
        end else begin
            valid_r <= valid_nx_s;
            count_r <= count_nx_s;
            if (alloc_en) begin
                line_r[free_idx]  <= alloc_line;
                instr_r[free_idx] <= alloc_instr;
            end
        end
    end

    assign rd_instr = instr_r[rd_idx];
    assign count    = count_r;

endmodule

// File: rtl/mem_req_initiator.sv
// Cache-side initiator for one parity side of the DRAM subsystem. Pushes L2
// requests into the memory data or instruction queue, tracks outstanding reads
// in the MSHR table and returns matched read responses to the cache as fills.
module mem_req_initiator
    import mem_if_pkg::*;
#(
    parameter int         CL_SIZE    = 128,
    parameter int         MSHR_DEPTH = 4,
    parameter logic [1:0] SRC_ID     = SRC_ID_DEF,
    parameter logic [1:0] MEM_ID     = MEM_ID_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [31:0]                     req_addr,
    input  logic [2:0]                      req_op,
    input  logic                            req_is_instr,
    input  logic                            req_is_flush,
    input  logic [CL_SIZE-1:0]              req_data,
    output logic [31:0]                     addr_out_mem_data_q,
    output logic [CL_SIZE-1:0]              data_out_mem_data_q,
    output logic [2:0]                      operation_out_mem_data_q,
    output logic                            is_flush_out_mem_data_q,
    output logic [1:0]                      src_out_mem_data_q,
    output logic [1:0]                      dest_out_mem_data_q,
    output logic                            alloc_out_mem_data_q,
    input  logic                            full_in_mem_data_q,
    output logic [31:0]                     addr_out_mem_instr_q,
    output logic [2:0]                      operation_out_mem_instr_q,
    output logic                            is_flush_out_mem_instr_q,
    output logic [1:0]                      src_out_mem_instr_q,
    output logic [1:0]                      dest_out_mem_instr_q,
    output logic                            alloc_out_mem_instr_q,
    input  logic                            full_in_mem_instr_q,
    input  logic [31:0]                     addr_in_resp,
    input  logic [CL_SIZE-1:0]              data_in_resp,
    input  logic [2:0]                      operation_in_resp,
    input  logic                            is_flush_in_resp,
    input  logic [1:0]                      src_in_resp,
    input  logic [1:0]                      dest_in_resp,
    input  logic                            alloc_in_resp,
    output logic                            full_out_resp,
    output logic                            fill_valid,
    input  logic                            fill_ready,
    output logic [31:0]                     fill_addr,
    output logic [CL_SIZE-1:0]              fill_data,
    output logic                            fill_is_instr,
    output logic [$clog2(MSHR_DEPTH+1)-1:0] outstanding,
    output logic                            err_unmatched
);

    localparam int OFF = line_off(CL_SIZE);
    localparam int LW  = 32 - OFF;
    localparam int IW  = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;
    localparam int CW  = $clog2(MSHR_DEPTH + 1);

    issue_state_e       state_r, state_nx_s;
    logic [31:0]        issue_addr_r;
    logic [CL_SIZE-1:0] issue_data_r;
    logic [2:0]         issue_op_r;
    logic               issue_flush_r;
    logic               issue_instr_r;
    logic               ready_en_r;
    logic               resp_v_r;
    logic [LW-1:0]      resp_line_r;
    logic [CL_SIZE-1:0] resp_data_r;
    logic [IW-1:0]      resp_idx_r;
    logic               err_r;

    logic          issue_v_s, rd_req_s, accept_s, push_s;
    logic          resp_take_s, fill_fire_s;
    logic          iss_hit_s, rsp_hit_s, mshr_free_s, rd_instr_s;
    logic [IW-1:0] rsp_idx_s, free_idx_s;
    logic [CW-1:0] count_s;
    logic          unused_resp_s;

    assign issue_v_s   = (state_r == ISS_HOLD);
    assign rd_req_s    = (req_op == OP_RD);
    // ready_en_r keeps req_ready low while reset is asserted regardless of req_op
    assign req_ready   = ready_en_r && !issue_v_s && (!rd_req_s || (mshr_free_s && !iss_hit_s));
    assign accept_s    = req_valid && req_ready;
    assign alloc_out_mem_data_q  = issue_v_s && !issue_instr_r && !full_in_mem_data_q;
    assign alloc_out_mem_instr_q = issue_v_s &&  issue_instr_r && !full_in_mem_instr_q;
    assign push_s      = alloc_out_mem_data_q || alloc_out_mem_instr_q;
    assign resp_take_s = alloc_in_resp && !resp_v_r && (dest_in_resp == SRC_ID);
    assign fill_fire_s = resp_v_r && fill_ready;
    assign unused_resp_s = ^{operation_in_resp, is_flush_in_resp, src_in_resp, addr_in_resp[OFF-1:0]};

    mem_mshr_table #(
        .DEPTH (MSHR_DEPTH),
        .LW    (LW),
        .IW    (IW),
        .CW    (CW)
    ) u_mshr (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_en    (accept_s && rd_req_s),
        .alloc_line  (req_addr[31:OFF]),
        .alloc_instr (req_is_instr),
        .retire_en   (fill_fire_s),
        .retire_idx  (resp_idx_r),
        .iss_line    (req_addr[31:OFF]),
        .iss_hit     (iss_hit_s),
        .rsp_line    (addr_in_resp[31:OFF]),
        .rsp_hit     (rsp_hit_s),
        .rsp_idx     (rsp_idx_s),
        .free        (mshr_free_s),
        .free_idx    (free_idx_s),
        .rd_idx      (resp_idx_r),
        .rd_instr    (rd_instr_s),
        .count       (count_s)
    );

    // Issue FSM next state: hold until the selected queue takes the push
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ISS_IDLE: begin
                if (accept_s) state_nx_s = ISS_HOLD;
                else          state_nx_s = ISS_IDLE;
            end
            ISS_HOLD: begin
                if (push_s && !accept_s) state_nx_s = ISS_IDLE;
                else                     state_nx_s = ISS_HOLD;
            end
            default: state_nx_s = ISS_IDLE;
        endcase
    end

    // Issue state and payload register; payload only changes on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ISS_IDLE;
            issue_addr_r  <= 32'd0;
            issue_data_r  <= {CL_SIZE{1'b0}};
            issue_op_r    <= 3'b000;
            issue_flush_r <= 1'b0;
            issue_instr_r <= 1'b0;
            ready_en_r    <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ready_en_r <= 1'b1;
            if (accept_s) begin
                issue_addr_r  <= req_addr;
                issue_data_r  <= req_data;
                issue_op_r    <= req_op;
                issue_flush_r <= req_is_flush;
                issue_instr_r <= req_is_instr;
            end
        end
    end

    // Response buffer: one matched read held until the cache takes the fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_v_r    <= 1'b0;
            resp_line_r <= {LW{1'b0}};
            resp_data_r <= {CL_SIZE{1'b0}};
            resp_idx_r  <= {IW{1'b0}};
            err_r       <= 1'b0;
        end else begin
            if (fill_fire_s) begin
                resp_v_r <= 1'b0;
            end else if (resp_take_s && rsp_hit_s) begin
                resp_v_r    <= 1'b1;
                resp_line_r <= addr_in_resp[31:OFF];
                resp_data_r <= data_in_resp;
                resp_idx_r  <= rsp_idx_s;
            end
            if (resp_take_s && !rsp_hit_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign addr_out_mem_data_q       = issue_addr_r;
    assign data_out_mem_data_q       = issue_data_r;
    assign operation_out_mem_data_q  = issue_op_r;
    assign is_flush_out_mem_data_q   = issue_flush_r;
    assign src_out_mem_data_q        = issue_v_s ? SRC_ID : 2'b00;
    assign dest_out_mem_data_q       = issue_v_s ? MEM_ID : 2'b00;
    assign addr_out_mem_instr_q      = issue_addr_r;
    assign operation_out_mem_instr_q = issue_op_r;
    assign is_flush_out_mem_instr_q  = issue_flush_r;
    assign src_out_mem_instr_q       = issue_v_s ? SRC_ID : 2'b00;
    assign dest_out_mem_instr_q      = issue_v_s ? MEM_ID : 2'b00;

    assign full_out_resp = resp_v_r;
    assign fill_valid    = resp_v_r;
    assign fill_addr     = {resp_line_r, {OFF{1'b0}}};
    assign fill_data     = resp_data_r;
    assign fill_is_instr = resp_v_r && rd_instr_s;
    assign outstanding   = count_s;
    assign err_unmatched = err_r;

endmodule
